// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: SPI command decoder sharing one RAM with a host port.
// SPI has priority; a starvation guard forces a host grant.
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH        = 8,
  parameter int DATA_WIDTH        = 8,
  parameter int HOST_STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH+1:0] spi_rx_data,
  input  logic                  spi_rx_valid,
  output logic [DATA_WIDTH-1:0] spi_tx_data,
  output logic                  spi_tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  err_overflow,
  input  logic                  clr_err,
  output logic                  busy
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = $clog2(HOST_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(HOST_STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          spi_pend_q, spi_pend_d;
  logic [AW+1:0] spi_cmd_q, spi_cmd_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_q, owner_d;
  logic          rd_q, rd_d;
  logic          ram_en_q, ram_en_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          host_gnt_q, host_gnt_d;
  logic          host_rvalid_q, host_rvalid_d;
  logic [DW-1:0] host_rdata_q, host_rdata_d;
  logic          tx_valid_q, tx_valid_d;
  logic [DW-1:0] tx_data_q, tx_data_d;
  logic          err_q, err_d;

  logic          idle;
  logic          pend_rd;
  logic [AW-1:0] pend_pl;
  logic          pend_latch;
  logic          pend_ram;
  logic          rx_ram;
  logic          starved;
  logic          host_win;
  logic          spi_win;
  logic          consume;
  logic          overflow;

  // Arbitration decode; an SPI RAM command arriving this edge
  // also holds the host off so simultaneous requests favour SPI.
  assign idle       = (state_q == IDLE);
  assign pend_rd    = spi_cmd_q[AW+1];
  assign pend_pl    = spi_cmd_q[AW-1:0];
  assign pend_latch = spi_pend_q & ~spi_cmd_q[AW];
  assign pend_ram   = spi_pend_q & spi_cmd_q[AW];
  assign rx_ram     = spi_rx_valid & spi_rx_data[AW];
  assign starved    = host_req & (starve_q == LIMIT);
  assign host_win   = idle & host_req & ~pend_latch
                    & (starved | (~pend_ram & ~rx_ram));
  assign spi_win    = idle & pend_ram & ~host_win;
  assign consume    = idle & (pend_latch | spi_win);
  assign overflow   = spi_rx_valid & spi_pend_q & ~consume;

  // One-entry SPI command buffer and sticky overflow flag.
  always_comb begin
    spi_pend_d = spi_pend_q;
    spi_cmd_d  = spi_cmd_q;
    if (consume) begin
      spi_pend_d = 1'b0;
    end
    if (spi_rx_valid && (!spi_pend_q || consume)) begin
      spi_pend_d = 1'b1;
      spi_cmd_d  = spi_rx_data;
    end
    err_d = err_q;
    if (overflow) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  // FSM next state and registered outputs.
  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    starve_d      = starve_q;
    owner_d       = owner_q;
    rd_d          = rd_q;
    ram_en_d      = ram_en_q;
    ram_we_d      = ram_we_q;
    ram_addr_d    = ram_addr_q;
    ram_wdata_d   = ram_wdata_q;
    host_gnt_d    = 1'b0;
    host_rvalid_d = 1'b0;
    host_rdata_d  = host_rdata_q;
    tx_valid_d    = 1'b0;
    tx_data_d     = tx_data_q;
    unique case (state_q)
      IDLE: begin
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        unique case (1'b1)
          pend_latch: begin
            if (pend_rd) rd_addr_d = pend_pl;
            else         wr_addr_d = pend_pl;
          end
          host_win: begin
            host_gnt_d  = 1'b1;
            ram_en_d    = 1'b1;
            ram_we_d    = host_we;
            ram_addr_d  = host_addr;
            ram_wdata_d = host_wdata;
            owner_d     = 1'b1;
            rd_d        = ~host_we;
            starve_d    = '0;
            state_d     = ACCESS;
          end
          spi_win: begin
            ram_en_d    = 1'b1;
            ram_we_d    = ~pend_rd;
            ram_wdata_d = DW'(pend_pl);
            owner_d     = 1'b0;
            rd_d        = pend_rd;
            if (pend_rd) begin
              ram_addr_d = rd_addr_q;
              rd_addr_d  = rd_addr_q + AW'(1);
            end else begin
              ram_addr_d = wr_addr_q;
              wr_addr_d  = wr_addr_q + AW'(1);
            end
            if (!host_req)          starve_d = '0;
            else if (starve_q != LIMIT)
              starve_d = starve_q + SW'(1);
            state_d     = ACCESS;
          end
          default: ;
        endcase
      end
      ACCESS: begin
        ram_en_d = 1'b0;
        ram_we_d = 1'b0;
        state_d  = rd_q ? RD_WAIT : IDLE;
      end
      RD_WAIT: begin
        if (owner_q) begin
          host_rvalid_d = 1'b1;
          host_rdata_d  = ram_rdata;
        end else begin
          tx_valid_d = 1'b1;
          tx_data_d  = ram_rdata;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      spi_pend_q    <= 1'b0;
      spi_cmd_q     <= '0;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      starve_q      <= '0;
      owner_q       <= 1'b0;
      rd_q          <= 1'b0;
      ram_en_q      <= 1'b0;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      spi_pend_q    <= spi_pend_d;
      spi_cmd_q     <= spi_cmd_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      starve_q      <= starve_d;
      owner_q       <= owner_d;
      rd_q          <= rd_d;
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      host_gnt_q    <= host_gnt_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      tx_valid_q    <= tx_valid_d;
      tx_data_q     <= tx_data_d;
      err_q         <= err_d;
    end
  end

  assign spi_tx_data  = tx_data_q;
  assign spi_tx_valid = tx_valid_q;
  assign host_gnt     = host_gnt_q;
  assign host_rvalid  = host_rvalid_q;
  assign host_rdata   = host_rdata_q;
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign err_overflow = err_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// tb_spi_ram_arbiter: directed table, corner sequences and
// randomized traffic against a transaction-level memory model.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic       host_rvalid;
  logic [7:0] host_rdata;
  logic       ram_en;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_wdata;
  logic [7:0] ram_rdata;
  logic       err_overflow;
  logic       clr_err;
  logic       busy;

  spi_ram_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_gnt     (host_gnt),
    .host_rvalid  (host_rvalid),
    .host_rdata   (host_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .err_overflow (err_overflow),
    .clr_err      (clr_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with a backdoor write port.
  logic [7:0] mem [0:255];
  logic       bd_we;
  logic [7:0] bd_addr;
  logic [7:0] bd_data;

  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_send(input logic [9:0] cmd);
    spi_rx_data  = cmd;
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_valid = 1'b0;
  endtask

  task automatic bd_write(input logic [7:0] a,
                          input logic [7:0] d);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_strb"},
        {25'd0, ram_en, ram_we, host_gnt, host_rvalid,
         spi_tx_valid, err_overflow, busy}, 32'd0);
    chk({tag, "_data"},
        {ram_addr, ram_wdata, host_rdata, spi_tx_data},
        32'd0);
  endtask

  typedef struct {
    logic [9:0] cmd;
    logic       ram;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       tx;
    logic [7:0] txd;
  } vec_t;

  // Send one SPI command and check RAM/tx timing and values.
  task automatic apply(input vec_t v, input string tag);
    int         en_k;
    int         tx_k;
    logic       we;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] td;
    en_k = 0;
    tx_k = 0;
    we   = 1'b0;
    a    = '0;
    d    = '0;
    td   = '0;
    spi_send(v.cmd);
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ram_en && en_k == 0) begin
        en_k = k;
        we   = ram_we;
        a    = ram_addr;
        d    = ram_wdata;
      end
      if (spi_tx_valid && tx_k == 0) begin
        tx_k = k;
        td   = spi_tx_data;
      end
    end
    chk({tag, "_en_cyc"}, en_k, v.ram ? 1 : 0);
    if (v.ram) begin
      chk({tag, "_we"}, we, v.we);
      chk({tag, "_addr"}, a, v.addr);
      chk({tag, "_wdata"}, d, v.wdata);
    end
    chk({tag, "_tx_cyc"}, tx_k, v.tx ? 3 : 0);
    if (v.tx) chk({tag, "_txd"}, td, v.txd);
  endtask

  // Behavioural model state for the random phase.
  logic [7:0] shadow [0:255];
  logic [7:0] expq [$];
  logic [7:0] m_wr;
  logic [7:0] m_rd;
  logic       rnd_on = 1'b0;

  always @(negedge clk) begin
    if (rnd_on && spi_tx_valid) begin
      if (expq.size() == 0) begin
        chk("rnd_tx_unexpected", 32'd1, 32'd0);
      end else begin
        chk("rnd_tx", spi_tx_data, expq.pop_front());
      end
    end
  end

  task automatic rnd_spi();
    logic [1:0] op;
    logic [7:0] pl;
    for (int i = 0; i < 40; i++) begin
      op = (i == 0) ? 2'b00 :
           (i == 1) ? 2'b10 : 2'($urandom_range(0, 3));
      pl = 8'($urandom_range(0, 255));
      if (!op[0]) pl = 8'($urandom_range(0, 63));
      case (op)
        2'b00: m_wr = pl;
        2'b01: begin
          shadow[m_wr] = pl;
          m_wr = m_wr + 8'd1;
        end
        2'b10: m_rd = pl;
        default: begin
          expq.push_back(shadow[m_rd]);
          m_rd = m_rd + 8'd1;
        end
      endcase
      spi_send({op, pl});
      repeat ($urandom_range(11, 16)) tick();
    end
  endtask

  task automatic rnd_host();
    int         w;
    logic       got;
    logic       is_wr;
    logic [7:0] a;
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 8)) tick();
      is_wr      = 1'($urandom_range(0, 1));
      a          = 8'($urandom_range(192, 255));
      d          = 8'($urandom_range(0, 255));
      host_we    = is_wr;
      host_addr  = a;
      host_wdata = d;
      host_req   = 1'b1;
      got        = 1'b0;
      w          = 0;
      while (!got && w < 40) begin
        tick();
        w++;
        if (host_gnt) got = 1'b1;
      end
      host_req = 1'b0;
      if (!got) begin
        chk("rnd_host_gnt_timeout", 32'd0, 32'd1);
      end else if (is_wr) begin
        shadow[a] = d;
      end else begin
        exp = shadow[a];
        got = 1'b0;
        w   = 0;
        while (!got && w < 6) begin
          tick();
          w++;
          if (host_rvalid) got = 1'b1;
        end
        chk("rnd_host_rvalid_seen", got, 1'b1);
        if (got) chk("rnd_host_rdata", host_rdata, exp);
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [12];
    int   sg;
    int   at;
    int   nsent;
    int   txs;
    int   bad;
    vecs[0]  = '{10'h005, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{10'h1A7, 1'b1, 1'b1, 8'h05, 8'hA7, 1'b0, 8'h00};
    vecs[2]  = '{10'h111, 1'b1, 1'b1, 8'h06, 8'h11, 1'b0, 8'h00};
    vecs[3]  = '{10'h2FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[4]  = '{10'h0FF, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[5]  = '{10'h13C, 1'b1, 1'b1, 8'hFF, 8'h3C, 1'b0, 8'h00};
    vecs[6]  = '{10'h199, 1'b1, 1'b1, 8'h00, 8'h99, 1'b0, 8'h00};
    vecs[7]  = '{10'h300, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h3C};
    vecs[8]  = '{10'h300, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h99};
    vecs[9]  = '{10'h205, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00};
    vecs[10] = '{10'h3EE, 1'b1, 1'b0, 8'h05, 8'hEE, 1'b1, 8'hA7};
    vecs[11] = '{10'h3EE, 1'b1, 1'b0, 8'h06, 8'hEE, 1'b1, 8'h11};

    rst_n        = 1'b0;
    spi_rx_data  = '0;
    spi_rx_valid = 1'b0;
    host_req     = 1'b0;
    host_we      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    clr_err      = 1'b0;
    bd_we        = 1'b0;
    bd_addr      = '0;
    bd_data      = '0;
    m_wr         = '0;
    m_rd         = '0;
    repeat (3) tick();
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Host read on an idle arbiter.
    bd_write(8'h10, 8'h55);
    tick();
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h10;
    tick();
    chk("b_gnt", {host_gnt, ram_en, ram_we, ram_addr},
        {1'b1, 1'b1, 1'b0, 8'h10});
    host_req = 1'b0;
    tick();
    chk("b_rvalid_early", host_rvalid, 1'b0);
    tick();
    chk("b_rdata", {host_rvalid, host_rdata, spi_tx_valid},
        {1'b1, 8'h55, 1'b0});
    repeat (2) tick();

    // SPI write and host write requested together.
    spi_send(10'h020);
    repeat (2) tick();
    spi_rx_data  = 10'h1C3;
    spi_rx_valid = 1'b1;
    host_req     = 1'b1;
    host_we      = 1'b1;
    host_addr    = 8'h30;
    host_wdata   = 8'h5A;
    tick();
    chk("c_gnt_t0", host_gnt, 1'b0);
    spi_rx_valid = 1'b0;
    tick();
    chk("c_spi_acc", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata},
        {1'b0, 1'b1, 1'b1, 8'h20, 8'hC3});
    tick();
    chk("c_gnt_t2", host_gnt, 1'b0);
    tick();
    chk("c_host_acc", {host_gnt, ram_en, ram_we, ram_addr, ram_wdata},
        {1'b1, 1'b1, 1'b1, 8'h30, 8'h5A});
    host_req = 1'b0;
    repeat (3) tick();

    // Starvation guard under back-to-back SPI writes.
    host_we    = 1'b1;
    host_addr  = 8'h31;
    host_wdata = 8'h77;
    host_req   = 1'b1;
    sg    = 0;
    at    = -1;
    nsent = 0;
    for (int t = 0; t < 16; t++) begin
      if (t % 2 == 0 && nsent < 5) begin
        spi_rx_data  = {2'b01, 8'(8'h60 + nsent)};
        spi_rx_valid = 1'b1;
        nsent++;
      end else begin
        spi_rx_valid = 1'b0;
      end
      tick();
      if (host_gnt && at < 0) begin
        at       = sg;
        host_req = 1'b0;
      end else if (ram_en) begin
        sg++;
      end
    end
    chk("d_spi_before_host", at, 4);
    chk("d_spi_total", sg, 5);
    chk("d_no_err", err_overflow, 1'b0);
    repeat (2) tick();

    // Overflow while the host read owns the RAM.
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 8'h10;
    tick();
    chk("e_gnt", host_gnt, 1'b1);
    host_req     = 1'b0;
    spi_rx_data  = 10'h040;
    spi_rx_valid = 1'b1;
    tick();
    spi_rx_data = 10'h077;
    tick();
    spi_rx_valid = 1'b0;
    chk("e_err_set", err_overflow, 1'b1);
    chk("e_rdata", {host_rvalid, host_rdata}, {1'b1, 8'h55});
    repeat (3) tick();
    apply('{10'h1AB, 1'b1, 1'b1, 8'h40, 8'hAB, 1'b0, 8'h00},
          "e_wr");
    chk("e_err_sticky", err_overflow, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("e_err_clr", err_overflow, 1'b0);

    // Reset in the middle of an SPI read.
    spi_send(10'h212);
    repeat (3) tick();
    spi_send(10'h300);
    tick();
    chk("f_ram_en", ram_en, 1'b1);
    rst_n = 1'b0;
    #2;
    check_zero("f_rst");
    tick();
    rst_n = 1'b1;
    txs = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (spi_tx_valid) txs++;
    end
    chk("f_no_tx", txs, 0);
    check_zero("f_after");

    // Randomized mixed traffic against the memory model.
    for (int a = 0; a < 256; a++) begin
      shadow[a] = 8'($urandom_range(0, 255));
      bd_write(8'(a), shadow[a]);
    end
    rnd_on = 1'b1;
    fork
      rnd_spi();
      rnd_host();
    join
    repeat (20) tick();
    rnd_on = 1'b0;
    chk("rnd_pending_tx", expq.size(), 0);
    chk("rnd_no_err", err_overflow, 1'b0);
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      if (mem[a] !== shadow[a]) bad++;
    end
    chk("rnd_mem_final", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
